multdiv_seq: RTL and testbench

//  Parametrised iterative multiplier/divider; next generation of the processor's multdiv unit.

---
 rtl/multdiv_seq.sv | 147 ++++++++++++++
 tb/tb_multdiv_seq.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/multdiv_seq.sv
// rtl/multdiv_seq.sv - iterative Booth multiply / restoring divide, fixed WIDTH+1 cycle latency.
// Optional unsigned mode (ctrl_UNSIGNED port) enabled by defining MULTDIV_UNSIGNED_EN.
module multdiv_seq #(
    parameter int WIDTH = 32
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [WIDTH-1:0] data_operandA,
    input  logic [WIDTH-1:0] data_operandB,
    input  logic             ctrl_MULT,
    input  logic             ctrl_DIV,
`ifdef MULTDIV_UNSIGNED_EN
    input  logic             ctrl_UNSIGNED,
`endif
    output logic [WIDTH-1:0] data_result,
    output logic [WIDTH-1:0] data_remainder,
    output logic             data_exception,
    output logic             data_resultRDY,
    output logic             busy
);
    localparam int CNT_W = $clog2(WIDTH + 1);
    localparam logic [WIDTH-1:0] MOST_NEG = {1'b1, {(WIDTH-1){1'b0}}};

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t             state;
    logic [CNT_W-1:0]   cnt;
    logic [2*WIDTH:0]   p;
    logic [WIDTH-1:0]   m;
    logic               mode_div, mode_uns, sign_a, sign_b, div_zero, div_ovf;

    logic               uns_in;
`ifdef MULTDIV_UNSIGNED_EN
    assign uns_in = ctrl_UNSIGNED;
`else
    assign uns_in = 1'b0;
`endif

    logic               start, start_div, op_add, op_sub;
    logic [WIDTH-1:0]   abs_a, abs_b;
    logic [WIDTH:0]     add_a, add_b, sum;
    logic [2*WIDTH:0]   p_next;
    logic [2*WIDTH-1:0] product;
    logic [WIDTH-1:0]   quo, rem;

    assign start     = ctrl_MULT | ctrl_DIV;
    assign start_div = ctrl_DIV & ~ctrl_MULT;
    assign abs_a     = (!uns_in && data_operandA[WIDTH-1]) ? -data_operandA : data_operandA;
    assign abs_b     = (!uns_in && data_operandB[WIDTH-1]) ? -data_operandB : data_operandB;

    // Multiply layout: p = {A, Q, q_-1}; divide layout: p = {0, R, Q}.
    assign op_add = mode_uns ? p[1] : (p[1:0] == 2'b01);
    assign op_sub = !mode_uns && (p[1:0] == 2'b10);

    always_comb begin
        add_a = '0;
        add_b = '0;
        if (mode_div) begin
            add_a = {p[2*WIDTH-1:WIDTH], p[WIDTH-1]};
            add_b = {1'b0, m};
        end else begin
            add_a = {(mode_uns ? 1'b0 : p[2*WIDTH]), p[2*WIDTH:WIDTH+1]};
            if (op_add || op_sub)
                add_b = {(mode_uns ? 1'b0 : m[WIDTH-1]), m};
        end
    end

    // The single shared adder; divide always subtracts the divisor.
    always_comb begin
        logic sub;
        sub = mode_div | op_sub;
        sum = add_a + (sub ? ~add_b : add_b) + {{WIDTH{1'b0}}, sub};
    end

    always_comb begin
        p_next = {sum, p[WIDTH:1]};
        if (mode_div)
            p_next = sum[WIDTH] ? {1'b0, p[2*WIDTH-2:0], 1'b0}
                                : {1'b0, sum[WIDTH-1:0], p[WIDTH-2:0], 1'b1};
    end

    assign product = p[2*WIDTH:1];
    assign quo     = p[WIDTH-1:0];
    assign rem     = p[2*WIDTH-1:WIDTH];

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state          <= IDLE;
            cnt            <= '0;
            p              <= '0;
            m              <= '0;
            mode_div       <= 1'b0;
            mode_uns       <= 1'b0;
            sign_a         <= 1'b0;
            sign_b         <= 1'b0;
            div_zero       <= 1'b0;
            div_ovf        <= 1'b0;
            data_result    <= '0;
            data_remainder <= '0;
            data_exception <= 1'b0;
            data_resultRDY <= 1'b0;
            busy           <= 1'b0;
        end else if (start) begin
            state          <= RUN;
            cnt            <= '0;
            mode_div       <= start_div;
            mode_uns       <= uns_in;
            sign_a         <= !uns_in && data_operandA[WIDTH-1];
            sign_b         <= !uns_in && data_operandB[WIDTH-1];
            div_zero       <= (data_operandB == '0);
            div_ovf        <= !uns_in && (data_operandA == MOST_NEG) && (data_operandB == '1);
            p              <= start_div ? {1'b0, {WIDTH{1'b0}}, abs_a}
                                        : {{WIDTH{1'b0}}, data_operandB, 1'b0};
            m              <= start_div ? abs_b : data_operandA;
            data_resultRDY <= 1'b0;
            busy           <= 1'b1;
        end else if (state == RUN) begin
            if (cnt != CNT_W'(WIDTH)) begin
                p   <= p_next;
                cnt <= cnt + 1'b1;
            end else begin
                state          <= DONE;
                busy           <= 1'b0;
                data_resultRDY <= 1'b1;
                if (!mode_div) begin
                    data_result    <= product[WIDTH-1:0];
                    data_remainder <= '0;
                    data_exception <= mode_uns ? (|product[2*WIDTH-1:WIDTH])
                                               : !((&product[2*WIDTH-1:WIDTH-1]) ||
                                                   !(|product[2*WIDTH-1:WIDTH-1]));
                end else if (div_zero) begin
                    data_result    <= '0;
                    data_remainder <= '0;
                    data_exception <= 1'b1;
                end else if (div_ovf) begin
                    data_result    <= MOST_NEG;
                    data_remainder <= '0;
                    data_exception <= 1'b1;
                end else begin
                    data_result    <= (sign_a ^ sign_b) ? -quo : quo;
                    data_remainder <= sign_a ? -rem : rem;
                    data_exception <= 1'b0;
                end
            end
        end
    end
endmodule

// File: tb/tb_multdiv_seq.sv
// tb/tb_multdiv_seq.sv - directed self-checking bench for multdiv_seq at WIDTH=32.
module tb_multdiv_seq;
    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic [31:0] data_operandA = '0;
    logic [31:0] data_operandB = '0;
    logic        ctrl_MULT = 1'b0;
    logic        ctrl_DIV = 1'b0;
    logic [31:0] data_result, data_remainder;
    logic        data_exception, data_resultRDY, busy;

    int errors = 0;
    int checks = 0;

    multdiv_seq #(.WIDTH(32)) dut (
        .clock(clock), .reset(reset),
        .data_operandA(data_operandA), .data_operandB(data_operandB),
        .ctrl_MULT(ctrl_MULT), .ctrl_DIV(ctrl_DIV),
        .data_result(data_result), .data_remainder(data_remainder),
        .data_exception(data_exception), .data_resultRDY(data_resultRDY),
        .busy(busy)
    );

    always #5 clock = ~clock;

    task automatic do_start(input logic [31:0] a, input logic [31:0] b, input bit is_div);
        @(negedge clock);
        data_operandA = a;
        data_operandB = b;
        ctrl_MULT     = !is_div;
        ctrl_DIV      = is_div;
        @(posedge clock);
        #1;
        ctrl_MULT     = 1'b0;
        ctrl_DIV      = 1'b0;
        data_operandA = 32'hDEAD_BEEF;
        data_operandB = 32'h0BAD_F00D;
    endtask

    task automatic wait_rdy(output int lat);
        lat = 0;
        while (!data_resultRDY && lat < 100) begin
            @(posedge clock);
            #1;
            lat++;
        end
    endtask

    task automatic test_reset;
        repeat (3) @(posedge clock);
        #1;
        checks++;
        if ({data_result, data_remainder, data_exception, data_resultRDY, busy} !== 67'd0) begin
            errors++;
            $display("FAIL reset_outputs: got res=%h rem=%h exc=%b rdy=%b busy=%b expected all 0",
                     data_result, data_remainder, data_exception, data_resultRDY, busy);
        end
        @(negedge clock);
        reset = 1'b0;
    endtask

    task automatic test_mult;
        logic [31:0] ta [6] = '{32'd7, 32'h7FFFFFFF, 32'h80000000, 32'd0, 32'hFFFFFFFF, 32'h00010000};
        logic [31:0] tb [6] = '{32'hFFFFFFFD, 32'h7FFFFFFF, 32'd1, 32'd12345, 32'hFFFFFFFF, 32'h00010000};
        logic [31:0] tr [6] = '{32'hFFFFFFEB, 32'h00000001, 32'h80000000, 32'd0, 32'd1, 32'd0};
        logic        te [6] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
        int lat;
        for (int i = 0; i < 6; i++) begin
            do_start(ta[i], tb[i], 1'b0);
            checks++;
            if (busy !== 1'b1 || data_resultRDY !== 1'b0) begin
                errors++;
                $display("FAIL mult%0d_busy: got busy=%b rdy=%b expected busy=1 rdy=0", i, busy, data_resultRDY);
            end
            wait_rdy(lat);
            checks++;
            if (lat !== 33) begin
                errors++;
                $display("FAIL mult%0d_latency: got %0d expected 33", i, lat);
            end
            checks++;
            if (data_result !== tr[i] || data_remainder !== 32'd0 || data_exception !== te[i] || busy !== 1'b0) begin
                errors++;
                $display("FAIL mult%0d_result: got res=%h rem=%h exc=%b busy=%b expected res=%h rem=0 exc=%b busy=0",
                         i, data_result, data_remainder, data_exception, busy, tr[i], te[i]);
            end
        end
    endtask

    task automatic test_div;
        logic [31:0] ta [6] = '{32'hFFFFFFF9, 32'd5, 32'h80000000, 32'd100, 32'd0, 32'd7};
        logic [31:0] tb [6] = '{32'd2, 32'd0, 32'hFFFFFFFF, 32'd7, 32'd3, 32'hFFFFFFFE};
        logic [31:0] tq [6] = '{32'hFFFFFFFD, 32'd0, 32'h80000000, 32'd14, 32'd0, 32'hFFFFFFFD};
        logic [31:0] tm [6] = '{32'hFFFFFFFF, 32'd0, 32'd0, 32'd2, 32'd0, 32'd1};
        logic        te [6] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
        int lat;
        for (int i = 0; i < 6; i++) begin
            do_start(ta[i], tb[i], 1'b1);
            wait_rdy(lat);
            checks++;
            if (lat !== 33) begin
                errors++;
                $display("FAIL div%0d_latency: got %0d expected 33", i, lat);
            end
            checks++;
            if (data_result !== tq[i] || data_remainder !== tm[i] || data_exception !== te[i]) begin
                errors++;
                $display("FAIL div%0d_result: got q=%h r=%h exc=%b expected q=%h r=%h exc=%b",
                         i, data_result, data_remainder, data_exception, tq[i], tm[i], te[i]);
            end
        end
    endtask

    task automatic test_hold;
        repeat (5) @(posedge clock);
        #1;
        checks++;
        if (data_resultRDY !== 1'b1 || data_result !== 32'hFFFFFFFD || data_remainder !== 32'd1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL hold_done: got rdy=%b res=%h rem=%h busy=%b expected rdy=1 res=fffffffd rem=00000001 busy=0",
                     data_resultRDY, data_result, data_remainder, busy);
        end
    endtask

    task automatic test_abort;
        int early_rdy = 0;
        int lat;
        do_start(32'd123, 32'd456, 1'b0);
        for (int i = 0; i < 9; i++) begin
            @(posedge clock);
            #1;
            if (data_resultRDY) early_rdy++;
        end
        do_start(32'd100, 32'd7, 1'b1);
        wait_rdy(lat);
        checks++;
        if (early_rdy !== 0 || lat !== 33) begin
            errors++;
            $display("FAIL abort_latency: got early_rdy=%0d lat=%0d expected early_rdy=0 lat=33", early_rdy, lat);
        end
        checks++;
        if (data_result !== 32'd14 || data_remainder !== 32'd2 || data_exception !== 1'b0) begin
            errors++;
            $display("FAIL abort_result: got q=%h r=%h exc=%b expected q=0000000e r=00000002 exc=0",
                     data_result, data_remainder, data_exception);
        end
    endtask

    task automatic test_reset_mid;
        int lat;
        do_start(32'd9, 32'd3, 1'b1);
        repeat (9) @(posedge clock);
        #2;
        reset = 1'b1;
        #1;
        checks++;
        if ({data_result, data_remainder, data_exception, data_resultRDY, busy} !== 67'd0) begin
            errors++;
            $display("FAIL reset_mid: got res=%h rem=%h exc=%b rdy=%b busy=%b expected all 0",
                     data_result, data_remainder, data_exception, data_resultRDY, busy);
        end
        @(negedge clock);
        reset = 1'b0;
        repeat (40) @(posedge clock);
        #1;
        checks++;
        if (data_resultRDY !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid_no_rdy: got rdy=%b busy=%b expected rdy=0 busy=0", data_resultRDY, busy);
        end
        do_start(32'hFFFFFFF6, 32'd4, 1'b0);
        wait_rdy(lat);
        checks++;
        if (lat !== 33 || data_result !== 32'hFFFFFFD8 || data_exception !== 1'b0) begin
            errors++;
            $display("FAIL after_reset_mult: got lat=%0d res=%h exc=%b expected lat=33 res=ffffffd8 exc=0",
                     lat, data_result, data_exception);
        end
    endtask

    initial begin
        test_reset;
        test_mult;
        test_div;
        test_hold;
        test_abort;
        test_reset_mid;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
